// File: rtl/debug_display_unit.sv
// Board-level display/debug unit. It holds the core's display register, a PC
// snapshot, a free-running cycle counter and a write counter. Any of these
// words can be paged onto the LED bank, either from the switches or by timed
// auto-scroll. A sticky halt flag freezes the counters and the captured state
// so the final values stay readable on the board.
//
// Handshake: wr_en is a single-cycle write strobe with no back-pressure. A
// write is accepted on every rising edge where wr_en=1 and halted=0.
module debug_display_unit #(
    parameter int DATA_W        = 32,
    parameter int LED_W         = 16,
    parameter int PAGES         = 2,
    parameter int PAGE_W        = 1,
    parameter int CNT_W         = 32,
    parameter int SCROLL_CYCLES = 50000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] pc,
    input  logic              halt,
    input  logic [1:0]        src_sel,
    input  logic [PAGE_W-1:0] page_sel,
    input  logic              auto_scroll,
    output logic [LED_W-1:0]  led,
    output logic              halted
);

    localparam int SC_W = (SCROLL_CYCLES > 2) ? $clog2(SCROLL_CYCLES) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCROLL_CYCLES - 1);

    logic [DATA_W-1:0] display_reg;
    logic [DATA_W-1:0] pc_cap;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  wr_cnt;
    logic [SC_W-1:0]   scroll_cnt;
    logic [PAGE_W-1:0] auto_page;

    logic              wr_accept;
    logic              running;
    logic [DATA_W-1:0] cycle_ext;
    logic [DATA_W-1:0] wr_ext;
    logic [DATA_W-1:0] sel_word;
    logic [PAGE_W-1:0] page;

    // A write in the cycle halt first rises still lands, since halted is not yet set.
    assign wr_accept = wr_en & ~halted;
    // Counting and PC capture stop in the very cycle halt rises.
    assign running   = ~halted & ~halt;

    // Sticky halt flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            halted <= 1'b0;
        end else if (halt) begin
            halted <= 1'b1;
        end
    end

    // Display register and saturating write counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            display_reg <= '0;
            wr_cnt      <= '0;
        end else if (wr_accept) begin
            display_reg <= wr_data;
            if (wr_cnt != '1) begin
                wr_cnt <= wr_cnt + CNT_W'(1);
            end
        end
    end

    // PC snapshot and saturating cycle counter, frozen once halt is seen.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_cap    <= '0;
            cycle_cnt <= '0;
        end else if (running) begin
            pc_cap <= pc;
            if (cycle_cnt != '1) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
        end
    end

    // Auto-scroll timer; leaving auto mode rewinds to page 0 with a full period.
    always_ff @(posedge clk) begin
        if (!reset_n || !auto_scroll) begin
            scroll_cnt <= '0;
            auto_page  <= '0;
        end else if (scroll_cnt == SC_LAST) begin
            scroll_cnt <= '0;
            auto_page  <= auto_page + PAGE_W'(1);
        end else begin
            scroll_cnt <= scroll_cnt + SC_W'(1);
        end
    end

    // Source word selection with zero-extended counters, and page choice.
    always_comb begin
        cycle_ext              = '0;
        cycle_ext[CNT_W-1:0]   = cycle_cnt;
        wr_ext                 = '0;
        wr_ext[CNT_W-1:0]      = wr_cnt;
        case (src_sel)
            2'd0:    sel_word = display_reg;
            2'd1:    sel_word = pc_cap;
            2'd2:    sel_word = cycle_ext;
            default: sel_word = wr_ext;
        endcase
        page = auto_scroll ? auto_page : page_sel;
    end

    // Registered LED drive: selected LED_W slice, page 0 is the LSB slice.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            led <= '0;
        end else begin
            led <= sel_word[int'(page) * LED_W +: LED_W];
        end
    end

endmodule

// File: tb/tb_debug_display_unit.sv
// Directed bench for debug_display_unit with a small scroll period and narrow
// counters so saturation and page cycling are reachable quickly.
module tb_debug_display_unit;

    localparam int DATA_W = 32;
    localparam int LED_W  = 16;
    localparam int PAGES  = 2;
    localparam int PAGE_W = 1;
    localparam int CNT_W  = 4;
    localparam int SCROLL = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] pc;
    logic              halt;
    logic [1:0]        src_sel;
    logic [PAGE_W-1:0] page_sel;
    logic              auto_scroll;
    logic [LED_W-1:0]  led;
    logic              halted;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    debug_display_unit #(
        .DATA_W(DATA_W), .LED_W(LED_W), .PAGES(PAGES), .PAGE_W(PAGE_W),
        .CNT_W(CNT_W), .SCROLL_CYCLES(SCROLL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data),
        .pc(pc), .halt(halt), .src_sel(src_sel), .page_sel(page_sel),
        .auto_scroll(auto_scroll), .led(led), .halted(halted)
    );

    // clock
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        wr_en       = 1'b0;
        wr_data     = '0;
        halt        = 1'b0;
        src_sel     = 2'd0;
        page_sel    = '0;
        auto_scroll = 1'b0;
        steps(2);
        reset_n = 1'b1;
    endtask

    task automatic write(input logic [31:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        pc = 32'h0;
        do_reset();

        // reset state and idle
        steps(3);
        check("idle_led", 32'(led), 32'h0);
        check("idle_halted", 32'(halted), 32'h0);
        src_sel = 2'd2;
        step();
        check("cyc_before_reset", 32'(led), 32'd3);
        reset_n = 1'b0;
        step();
        check("mid_reset_led", 32'(led), 32'h0);
        reset_n = 1'b1;
        step();
        check("cyc_after_reset0", 32'(led), 32'h0);
        step();
        check("cyc_after_reset1", 32'(led), 32'h1);

        // display register write and paging
        do_reset();
        write(32'h1234_000F);
        step();
        check("wr_page0", 32'(led), 32'h0000_000F);
        page_sel = 1'b1;
        step();
        check("wr_page1", 32'(led), 32'h0000_1234);

        // halt freezes cycle counter and PC capture
        do_reset();
        src_sel = 2'd2;
        for (int i = 0; i < 10; i++) begin
            pc = 32'h0040_0000 + 32'(4 * i);
            step();
        end
        halt = 1'b1;
        pc   = $urandom();
        steps(2);
        check("halt_cyc", 32'(led), 32'd10);
        check("halt_flag", 32'(halted), 32'h1);
        for (int i = 0; i < 20; i++) begin
            pc = $urandom();
            step();
            check("halt_cyc_hold", 32'(led), 32'd10);
        end
        halt = 1'b0;
        step();
        check("halt_sticky", 32'(halted), 32'h1);
        src_sel = 2'd1;
        step();
        check("pc_cap_lo", 32'(led), 32'h0000_0024);
        page_sel = 1'b1;
        step();
        check("pc_cap_hi", 32'(led), 32'h0000_0040);

        // write in the halt cycle lands, the next one does not
        do_reset();
        halt    = 1'b1;
        wr_en   = 1'b1;
        wr_data = 32'hAAAA_5555;
        step();
        halt    = 1'b0;
        wr_data = 32'h1111_2222;
        step();
        wr_en = 1'b0;
        step();
        check("halt_wr_lo", 32'(led), 32'h0000_5555);
        page_sel = 1'b1;
        step();
        check("halt_wr_hi", 32'(led), 32'h0000_AAAA);
        src_sel  = 2'd3;
        page_sel = 1'b0;
        step();
        check("halt_wr_cnt", 32'(led), 32'h1);

        // auto-scroll: 4 cycles per page starting at page 0
        do_reset();
        write(32'hBEEF_CAFE);
        page_sel    = 1'b1;
        auto_scroll = 1'b1;
        for (int k = 0; k < 12; k++) exp_q.push_back(((k / 4) % 2) == 1 ? 32'hBEEF : 32'hCAFE);
        while (exp_q.size() > 0) begin
            step();
            check("scroll", 32'(led), exp_q.pop_front());
        end
        auto_scroll = 1'b0;
        step();
        check("manual_p1", 32'(led), 32'h0000_BEEF);
        page_sel = 1'b0;
        step();
        check("manual_p0", 32'(led), 32'h0000_CAFE);
        page_sel    = 1'b1;
        auto_scroll = 1'b1;
        for (int k = 0; k < 8; k++) exp_q.push_back(k < 4 ? 32'hCAFE : 32'hBEEF);
        while (exp_q.size() > 0) begin
            step();
            check("rescroll", 32'(led), exp_q.pop_front());
        end
        auto_scroll = 1'b0;

        // write counter saturation
        do_reset();
        src_sel = 2'd3;
        wr_en   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr_data = $urandom();
            step();
        end
        wr_en = 1'b0;
        step();
        check("wr_cnt_sat", 32'(led), 32'h0000_000F);
        page_sel = 1'b1;
        step();
        check("wr_cnt_sat_hi", 32'(led), 32'h0);

        // cycle counter saturation
        do_reset();
        src_sel = 2'd2;
        steps(30);
        check("cyc_sat", 32'(led), 32'h0000_000F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/debug_display_unit.md
Name: debug_display_unit

Overview:
Parametrised board-level display/debug unit placed between the processor core and the LED bank in the top-level design. It holds the core's display register, a PC snapshot, a free-running cycle counter and a write counter. It pages any of these words onto LED_W LEDs, either from the switches or by timed auto-scroll. It also latches processor halt, freezing the counters so the final state stays readable on the board.

Parameters:
DATA_W, 32, width of display register and of every selectable source word; must equal LED_W * PAGES
LED_W, 16, number of LEDs driven
PAGES, 2, LED_W-wide slices per word; power of 2, >= 2
PAGE_W, 1, log2(PAGES)
CNT_W, 32, width of cycle and write counters (<= DATA_W)
SCROLL_CYCLES, 50000000, clock cycles per page in auto-scroll mode (>= 2)

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  synchronous active-low reset
wr_en  in  1  display-register write strobe from core
wr_data  in  DATA_W  display-register write value
pc  in  DATA_W  current core PC
halt  in  1  core halt indication
src_sel  in  2  source word: 0 display_reg, 1 pc_cap, 2 cycle_cnt, 3 wr_cnt
page_sel  in  PAGE_W  manual page (switches)
auto_scroll  in  1  1 = timed page cycling, 0 = manual page
led  out  LED_W  registered LED drive
halted  out  1  sticky halt flag

Behaviour:
- Reset (reset_n=0 at clk edge): display_reg, pc_cap, cycle_cnt, wr_cnt, scroll_cnt, auto_page, led all 0; halted 0. Reset wins over every other event in the same cycle, including mid-scroll and mid-write.
- halted: set on the first edge with halt=1. Cleared only by reset.
- display_reg: loads wr_data on edges where wr_en=1 and halted=0. wr_en in the same cycle halt first rises is accepted, because halted is still 0. wr_en is ignored from the next cycle on.
- wr_cnt: +1 per accepted write. Saturates at all-ones and does not wrap.
- cycle_cnt: +1 each edge while halted=0 and halt=0. The cycle where halt rises is not counted. Saturates at all-ones.
- pc_cap: samples pc each edge while halted=0 and halt=0. It therefore holds the PC of the last cycle before halt.
- Counter words narrower than DATA_W are zero-extended for display.
- Page selection:
  - Manual (auto_scroll=0): page = page_sel.
  - Auto (auto_scroll=1): scroll_cnt counts 0..SCROLL_CYCLES-1. On the edge where it equals SCROLL_CYCLES-1 it returns to 0 and auto_page advances. auto_page wraps from PAGES-1 to 0.
  - On any edge with auto_scroll=0, scroll_cnt and auto_page are cleared to 0. Entering auto mode therefore always starts at page 0 with a full period.
  - Scrolling continues after halt.
- led: led <= selected_word[page*LED_W +: LED_W], registered, one-cycle latency from any change of src_sel, page_sel, auto_scroll or source value. page 0 = least-significant slice.
- halted state changes nothing on the LED path except freezing the sources.
- No combinational path from inputs to outputs.

Test Plan:
- Reset, then idle 3 cycles -> led=0x0000 and halted=0. Then assert reset_n=0 mid-run with cycle_cnt nonzero -> next edge cycle_cnt=0, led=0.
- wr_en=1 with wr_data=0x1234_000F, src_sel=0, page_sel=0 -> led=0x000F one cycle after the write is visible. Set page_sel=1 -> led=0x1234 one cycle later.
- Release reset, run 10 cycles, raise halt. With src_sel=2 -> led reads 10 and stays 10 for 20 more cycles; halted=1. Drop halt -> halted stays 1.
- Assert halt and wr_en (data 0xAAAA_5555) together, then wr_en (data 0x1111_2222) next cycle -> display_reg=0xAAAA_5555 and wr_cnt=1. The second write is ignored.
- Use SCROLL_CYCLES=4, PAGES=2, set auto_scroll=1 with display_reg=0xBEEF_CAFE -> led alternates 0xCAFE/0xBEEF every 4 cycles, starting 0xCAFE. Drop auto_scroll -> led follows page_sel next cycle.
- Use CNT_W=4, issue 20 writes -> wr_cnt reads 0x0000_000F on page 0 and does not wrap.
